// File: rtl/riscv_core_divider.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Valid/ready request in, valid/ready result out; one quotient bit per cycle.
module riscv_core_divider #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  input  logic [WIDTH-1:0] i_div_dividend,
  input  logic [WIDTH-1:0] i_div_divisor,
  input  logic             i_div_signed,
  output logic             o_div_valid,
  input  logic             i_div_result_ready,
  output logic [WIDTH-1:0] o_div_quotient,
  output logic [WIDTH-1:0] o_div_remainder,
  output logic             o_div_busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             div_by_zero;
  logic             signed_ovf;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   diff_d;
  logic             fits_d;
  logic [WIDTH-1:0] rem_step_d;
  logic [WIDTH-1:0] quo_step_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  // Two's-complement negate stays in WIDTH bits, so the most-negative value
  // maps onto its exact unsigned magnitude.
  assign dvd_neg = i_div_signed & i_div_dividend[WIDTH-1];
  assign dvs_neg = i_div_signed & i_div_divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~i_div_dividend + WIDTH'(1)) : i_div_dividend;
  assign dvs_mag = dvs_neg ? (~i_div_divisor + WIDTH'(1)) : i_div_divisor;

  assign div_by_zero = (i_div_divisor == '0);
  assign signed_ovf  = i_div_signed && (i_div_dividend == MIN_VAL) && (i_div_divisor == '1);

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract, and keep the difference only if it did not borrow.
  assign shifted_d  = {rem_q, quo_q[WIDTH-1]};
  assign diff_d     = shifted_d - {1'b0, dvs_q};
  assign fits_d     = ~diff_d[WIDTH];
  assign rem_step_d = fits_d ? diff_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
  assign quo_step_d = {quo_q[WIDTH-2:0], fits_d};

  assign quo_fix_d = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign rem_fix_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates in one edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_div_valid) begin
            ready_q <= 1'b0;
            if (div_by_zero) begin
              quo_q   <= '1;
              rem_q   <= i_div_dividend;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else if (signed_ovf) begin
              quo_q   <= i_div_dividend;
              rem_q   <= '0;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              quo_q     <= dvd_mag;
              rem_q     <= '0;
              dvs_q     <= dvs_mag;
              neg_quo_q <= dvd_neg ^ dvs_neg;
              neg_rem_q <= dvd_neg;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_CALC;
            end
          end
        end

        S_CALC: begin
          quo_q <= quo_step_d;
          rem_q <= rem_step_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          quo_q   <= quo_fix_d;
          rem_q   <= rem_fix_d;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end

        S_DONE: begin
          if (i_div_result_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_div_ready     = ready_q;
  assign o_div_valid     = valid_q;
  assign o_div_busy      = busy_q;
  assign o_div_quotient  = quo_q;
  assign o_div_remainder = rem_q;

endmodule

// File: tb/tb_riscv_core_divider.sv
// Self-checking bench for riscv_core_divider: a handshake monitor compares
// every result cycle against an arithmetic reference model.
module tb_riscv_core_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_V = 64'h8000_0000_0000_0000;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_div_valid = 1'b0;
  logic         o_div_ready;
  logic [W-1:0] i_div_dividend = '0;
  logic [W-1:0] i_div_divisor = '0;
  logic         i_div_signed = 1'b0;
  logic         o_div_valid;
  logic         i_div_result_ready = 1'b0;
  logic [W-1:0] o_div_quotient;
  logic [W-1:0] o_div_remainder;
  logic         o_div_busy;

  riscv_core_divider #(.WIDTH(W)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_div_valid        (i_div_valid),
    .o_div_ready        (o_div_ready),
    .i_div_dividend     (i_div_dividend),
    .i_div_divisor      (i_div_divisor),
    .i_div_signed       (i_div_signed),
    .o_div_valid        (o_div_valid),
    .i_div_result_ready (i_div_result_ready),
    .o_div_quotient     (o_div_quotient),
    .o_div_remainder    (o_div_remainder),
    .o_div_busy         (o_div_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;
  int cycle = 0;

  always @(posedge i_clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    int           acc;
    bit           seen;
  } exp_t;

  exp_t exp_q[$];

  // RISC-V division semantics straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa;
    longint sb;
    e.seen = 1'b0;
    e.acc  = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.lat = 1;
    end else if (s && a == MIN_V && b == '1) begin
      e.q = a; e.r = '0; e.lat = 1;
    end else if (s) begin
      sa = longint'(a);
      sb = longint'(b);
      e.q = 64'(sa / sb);
      e.r = 64'(sa % sb);
      e.lat = W + 2;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = W + 2;
    end
    return e;
  endfunction

  bit post_reset = 1'b0;
  bit expect_ready = 1'b0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      post_reset   = 1'b1;
      expect_ready = 1'b0;
    end else begin
      if (post_reset) begin
        check("reset_ready", 64'(o_div_ready), 64'd1);
        check("reset_valid", 64'(o_div_valid), 64'd0);
        check("reset_busy", 64'(o_div_busy), 64'd0);
        check("reset_quotient", o_div_quotient, 64'd0);
        check("reset_remainder", o_div_remainder, 64'd0);
        post_reset = 1'b0;
      end
      check("state_onehot", 64'($countones({o_div_ready, o_div_valid, o_div_busy})), 64'd1);
      if (expect_ready) begin
        check("ready_after_handshake", 64'(o_div_ready), 64'd1);
        expect_ready = 1'b0;
      end
      if (o_div_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 64'(o_div_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q[0];
          if (!e.seen) begin
            check("latency", 64'(cycle - e.acc + 1), 64'(e.lat));
            e.seen = 1'b1;
            exp_q[0] = e;
          end
          check("quotient", o_div_quotient, e.q);
          check("remainder", o_div_remainder, e.r);
          if (i_div_result_ready) begin
            void'(exp_q.pop_front());
            expect_ready = 1'b1;
          end
        end
      end else if (exp_q.size() != 0 && (cycle - exp_q[0].acc) > 3 * W) begin
        check("result_timeout", 64'(o_div_valid), 64'd1);
        void'(exp_q.pop_front());
      end
      if (i_div_valid && o_div_ready) begin
        exp_t e;
        e = model(i_div_dividend, i_div_divisor, i_div_signed);
        e.acc = cycle + 1;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    @(posedge i_clk); #1;
    i_div_dividend = a;
    i_div_divisor  = b;
    i_div_signed   = s;
    i_div_valid    = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge i_clk);
      if (o_div_ready) begin
        acc = cycle + 1;
        got = 1'b1;
      end
    end
    if (!got) check("accept_timeout", 64'(o_div_ready), 64'd1);
    @(posedge i_clk); #1;
    i_div_valid = 1'b0;
  endtask

  task automatic wait_result(input int acc, output logic [W-1:0] q, output logic [W-1:0] r,
                             output int lat);
    bit got;
    got = 1'b0;
    q = '0; r = '0; lat = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge i_clk);
      if (o_div_valid) begin
        q   = o_div_quotient;
        r   = o_div_remainder;
        lat = cycle - acc + 1;
        got = 1'b1;
      end
    end
    if (!got) check("wait_timeout", 64'(o_div_valid), 64'd1);
  endtask

  task automatic release_result(input int hold);
    repeat (hold) @(negedge i_clk);
    @(posedge i_clk); #1;
    i_div_result_ready = 1'b1;
    @(posedge i_clk); #1;
    i_div_result_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, output logic [W-1:0] q, output logic [W-1:0] r,
                        output int lat);
    int acc;
    drive_req(a, b, s, acc);
    wait_result(acc, q, r, lat);
    release_result(hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           lat;
    int           acc;
    int           vcount;

    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("init_ready", 64'(o_div_ready), 64'd1);
    check("init_busy", 64'(o_div_busy), 64'd0);

    run_op(64'd100, 64'd7, 1'b0, 0, q, r, lat);
    check("udiv_100_7_q", q, 64'd14);
    check("udiv_100_7_r", r, 64'd2);
    check("udiv_100_7_lat", 64'(lat), 64'd66);

    run_op(-64'sd7, 64'd2, 1'b1, 1, q, r, lat);
    check("sdiv_m7_2_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
    check("sdiv_m7_2_r", r, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(64'd7, -64'sd2, 1'b1, 0, q, r, lat);
    check("sdiv_7_m2_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
    check("sdiv_7_m2_r", r, 64'd1);

    for (int m = 0; m < 2; m++) begin
      run_op(64'd5, 64'd0, 1'(m), 0, q, r, lat);
      check("div0_q", q, 64'hFFFF_FFFF_FFFF_FFFF);
      check("div0_r", r, 64'd5);
      check("div0_lat", 64'(lat), 64'd1);
    end

    run_op(MIN_V, '1, 1'b1, 0, q, r, lat);
    check("ovf_q", q, MIN_V);
    check("ovf_r", r, 64'd0);
    check("ovf_lat", 64'(lat), 64'd1);

    run_op(MIN_V, '1, 1'b0, 0, q, r, lat);
    check("umin_q", q, 64'd0);
    check("umin_r", r, MIN_V);
    check("umin_lat", 64'(lat), 64'd66);

    // Result held for ten cycles; the monitor re-checks it every cycle.
    run_op(64'd1000, 64'd3, 1'b0, 10, q, r, lat);
    check("hold_q", q, 64'd333);
    check("hold_r", r, 64'd1);

    // Scramble all request inputs while the divider is busy.
    drive_req(64'd100, 64'd7, 1'b0, acc);
    repeat (20) begin
      @(posedge i_clk); #1;
      i_div_dividend = {$urandom, $urandom};
      i_div_divisor  = {$urandom, $urandom};
      i_div_signed   = 1'($urandom_range(0, 1));
      i_div_valid    = 1'($urandom_range(0, 1));
    end
    i_div_valid = 1'b0;
    wait_result(acc, q, r, lat);
    release_result(0);
    check("toggle_q", q, 64'd14);
    check("toggle_r", r, 64'd2);

    // New request presented during the result handshake must wait one cycle.
    drive_req(64'd50, 64'd6, 1'b0, acc);
    wait_result(acc, q, r, lat);
    @(posedge i_clk); #1;
    i_div_result_ready = 1'b1;
    i_div_valid        = 1'b1;
    i_div_dividend     = 64'd9;
    i_div_divisor      = 64'd0;
    @(posedge i_clk); #1;
    i_div_result_ready = 1'b0;
    @(negedge i_clk);
    check("overlap_ready", 64'(o_div_ready), 64'd1);
    acc = cycle + 1;
    @(posedge i_clk); #1;
    i_div_valid = 1'b0;
    wait_result(acc, q, r, lat);
    release_result(0);
    check("overlap_q", q, 64'hFFFF_FFFF_FFFF_FFFF);
    check("overlap_r", r, 64'd9);

    // Reset in the middle of CALC discards the operation.
    drive_req(64'd123456789, 64'd97, 1'b0, acc);
    repeat (29) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("midrst_ready", 64'(o_div_ready), 64'd1);
    check("midrst_busy", 64'(o_div_busy), 64'd0);
    check("midrst_valid", 64'(o_div_valid), 64'd0);
    vcount = 0;
    repeat (80) begin
      @(negedge i_clk);
      if (o_div_valid) vcount++;
    end
    check("midrst_no_result", 64'(vcount), 64'd0);
    run_op(64'd100, 64'd7, 1'b0, 0, q, r, lat);
    check("after_rst_q", q, 64'd14);
    check("after_rst_r", r, 64'd2);

    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
        2: begin a = {$urandom, $urandom}; b = '0; end
        3: begin a = MIN_V; b = '1; end
        4: begin a = {$urandom, $urandom}; b = -64'($urandom_range(1, 20)); end
        default: begin a = MIN_V; b = 64'($urandom); end
      endcase
      run_op(a, b, s, $urandom_range(0, 3), q, r, lat);
    end

    repeat (5) @(negedge i_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_core_divider.md
RISCV_CORE_DIVIDER -- requirements
Module: riscv_core_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous and active-low.
REQ-004 i_div_valid  input  1  operand request valid.
REQ-005 o_div_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 i_div_dividend  input  WIDTH  dividend.
REQ-007 i_div_divisor  input  WIDTH  divisor.
REQ-008 i_div_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 o_div_valid  output  1  result valid; high only in DONE.
REQ-010 i_div_result_ready  input  1  consumer accepts result.
REQ-011 o_div_quotient  output  WIDTH  quotient.
REQ-012 o_div_remainder  output  WIDTH  remainder.
REQ-013 o_div_busy  output  1  high in CALC or FIX.

Function
REQ-014 A request SHALL be accepted on a rising edge where i_div_valid && o_div_ready; operands and i_div_signed SHALL be captured on that edge, and later input changes SHALL have no effect.
REQ-015 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-016 IDLE -> CALC on accept, unless a special case (REQ-021, REQ-022) applies; then IDLE -> DONE.
REQ-017 CALC SHALL run exactly WIDTH cycles of radix-2 restoring division on operand magnitudes, producing one quotient bit per cycle MSB-first, with a 6-bit (log2 WIDTH) iteration counter; counter terminal value -> FIX.
REQ-018 FIX (1 cycle) SHALL apply signs: quotient negated when signed and operand signs differ; remainder negated when signed and dividend is negative. FIX -> DONE.
REQ-019 Normal-path latency: o_div_valid SHALL first be high WIDTH+2 cycles after the accept edge (66 for WIDTH=64).
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder, truncating toward zero, with the remainder sign equal to the dividend sign (RISC-V DIV/DIVU/REM/REMU).
REQ-021 Divisor == 0: quotient SHALL be all ones and remainder SHALL be the dividend, in either signedness mode.
REQ-022 Signed overflow (dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): quotient SHALL be the dividend and remainder SHALL be 0.
REQ-023 Special-case latency: o_div_valid SHALL be high the cycle after the accept edge.
REQ-024 DONE -> IDLE on a rising edge with i_div_result_ready high; o_div_ready SHALL be high in the following cycle; a new request SHALL NOT be accepted in the same cycle as the result handshake.
REQ-025 While o_div_valid is high and i_div_result_ready is low, o_div_quotient and o_div_remainder SHALL hold stable.
REQ-026 The magnitude of the most-negative operand SHALL be formed as an unsigned WIDTH-bit value without loss.
REQ-027 i_div_valid in CALC, FIX or DONE SHALL be ignored.

Reset
REQ-028 When i_rst_n is low at a rising edge, in any state including mid-CALC, the FSM SHALL go to IDLE, the counter SHALL clear, and any in-flight operation SHALL be discarded without producing a result.
REQ-029 Outputs SHALL read as follows in the cycle after reset: o_div_ready=1, o_div_valid=0, o_div_busy=0, o_div_quotient=0, o_div_remainder=0.

Verification
REQ-030 Unsigned 100 / 7 -> quotient 14, remainder 2; o_div_valid first high 66 cycles after accept.
REQ-031 Signed -7 / 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3), remainder 0xFFFF_FFFF_FFFF_FFFF (-1); signed 7 / -2 -> quotient -3, remainder 1.
REQ-032 Divide by zero: 5 / 0 (both modes) -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, o_div_valid the cycle after accept.
REQ-033 Signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> quotient 0x8000_0000_0000_0000, remainder 0, one-cycle latency; same operands unsigned -> quotient 0, remainder 0x8000_0000_0000_0000 after 66 cycles.
REQ-034 Hold i_div_result_ready low for 10 cycles in DONE -> o_div_valid and both results stay constant; toggle operand inputs during CALC -> result unchanged.
REQ-035 Assert i_rst_n low at CALC iteration 30 -> next cycle o_div_ready=1, o_div_busy=0, o_div_valid=0, and no result appears; a fresh 100 / 7 then completes correctly.
